// File: rtl/mux_scan_sequencer_pkg.sv
// ============================================================================
// mux_scan_sequencer_pkg : shared state encodings, mux-compatible defaults and
//                          a slot-counter width helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mux_scan_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 7;
    localparam int DEFAULT_SEL_W = 3;

    // A one-cycle slot still needs a 1-bit counter to hold the reload value 0.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bit_slot_timer.sv
// ============================================================================
// bit_slot_timer : loadable down-counter that stops at zero and flags it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bit_slot_timer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int CNT_W = cnt_width(4)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_value_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
// ============================================================================
// mux_scan_sequencer : captures a word and steps the mux select through it,
//                      LSB first. Define MUX_SCAN_REPEAT_EN for gapless repeat.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int SEL_W          = DEFAULT_SEL_W,
    parameter int CYCLES_PER_BIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_in_i,
    output logic [WIDTH-1:0] word_out_o,
    output logic [SEL_W-1:0] mux_select_o,
    output logic             bit_strobe_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int               CNT_W    = cnt_width(CYCLES_PER_BIT);
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               strobe_q, strobe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               timer_load;
    logic               slot_end;

    bit_slot_timer #(
        .CNT_W(CNT_W)
    ) u_slot_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (timer_load),
        .load_value_i(RELOAD),
        .zero_o      (slot_end)
    );

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        sel_d      = sel_q;
        strobe_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timer_load = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start_i) begin
                    word_d     = data_in_i;
                    sel_d      = '0;
                    timer_load = 1'b1;
                    strobe_d   = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (slot_end) begin
                    if (sel_q < LAST_SEL) begin
                        sel_d      = sel_q + SEL_W'(1);
                        timer_load = 1'b1;
                        strobe_d   = 1'b1;
                    end else begin
`ifdef MUX_SCAN_REPEAT_EN
                        if (start_i) begin
                            word_d     = data_in_i;
                            sel_d      = '0;
                            timer_load = 1'b1;
                            strobe_d   = 1'b1;
                            done_d     = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
`else
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            sel_q    <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            sel_q    <= sel_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign word_out_o   = word_q;
    assign mux_select_o = sel_q;
    assign bit_strobe_o = strobe_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
// ============================================================================
// tb_mux_scan_sequencer : directed self-checking bench; DUT A uses 4 clocks
//                         per bit, DUT B uses 1 clock per bit with Start held.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, start_a, start_b;
    logic [6:0] data_a, data_b;
    logic [6:0] word_a, word_b;
    logic [2:0] sel_a, sel_b;
    logic       strobe_a, strobe_b, busy_a, busy_b, done_a, done_b;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [6:0] WORD_1 = 7'b1011001;
    localparam logic [6:0] BITS_1 = 7'b1011001;

    always #5 clk = ~clk;

    mux_scan_sequencer #(.WIDTH(7), .SEL_W(3), .CYCLES_PER_BIT(4)) u_dut_a (
        .clk_i(clk), .rst_i(rst_a), .start_i(start_a), .data_in_i(data_a),
        .word_out_o(word_a), .mux_select_o(sel_a), .bit_strobe_o(strobe_a),
        .busy_o(busy_a), .done_o(done_a)
    );

    mux_scan_sequencer #(.WIDTH(7), .SEL_W(3), .CYCLES_PER_BIT(1)) u_dut_b (
        .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .data_in_i(data_b),
        .word_out_o(word_b), .mux_select_o(sel_b), .bit_strobe_o(strobe_b),
        .busy_o(busy_b), .done_o(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start sampled at edge 0; cycle k is observed 1 ns after edge k.
    task automatic run_scan(input bit disturb);
        logic [6:0] bits;
        bits    = BITS_1;
        data_a  = WORD_1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int k = 0; k < 30; k++) begin
            chk("scan_word",   word_a, WORD_1);
            chk("scan_busy",   busy_a, (k < 28));
            chk("scan_sel",    sel_a, (k < 28) ? (k / 4) : 6);
            chk("scan_strobe", strobe_a, (k < 28) && (k % 4 == 0));
            chk("scan_done",   done_a, (k == 28));
            chk("scan_serial", word_a[sel_a], bits[(k < 28) ? (k / 4) : 6]);
            if (disturb && k == 9) begin
                start_a = 1'b1;
                data_a  = 7'h7F;
            end
            if (k == 10) start_a = 1'b0;
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        data_a = '0; data_b = 7'h55;
        step(); step();
        chk("rst_word",   word_a, 0);
        chk("rst_sel",    sel_a, 0);
        chk("rst_strobe", strobe_a, 0);
        chk("rst_busy",   busy_a, 0);
        chk("rst_done",   done_a, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        step(); step();
        chk("idle_busy", busy_a, 0);
        chk("idle_sel",  sel_a, 0);

        run_scan(1'b0);
        run_scan(1'b1);

        // Abort: reset lands mid-cycle after edge 13 and must clear outputs at once.
        data_a  = WORD_1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int k = 0; k < 13; k++) step();
        chk("pre_abort_busy", busy_a, 1);
        chk("pre_abort_sel",  sel_a, 3);
        #2 rst_a = 1'b1;
        #1;
        chk("abort_busy",   busy_a, 0);
        chk("abort_sel",    sel_a, 0);
        chk("abort_word",   word_a, 0);
        chk("abort_strobe", strobe_a, 0);
        chk("abort_done",   done_a, 0);
        step();
        #3 rst_a = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 35; k++) begin
            step();
            if (done_a) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_idle_busy", busy_a, 0);
        run_scan(1'b0);

        // Back-to-back with Start held, one clock per bit.
        data_b  = 7'h55;
        start_b = 1'b1;
        step();
        for (int k = 0; k < 30; k++) begin
`ifdef MUX_SCAN_REPEAT_EN
            chk("b2b_busy",   busy_b, 1);
            chk("b2b_sel",    sel_b, k % 7);
            chk("b2b_strobe", strobe_b, 1);
            chk("b2b_done",   done_b, (k > 0) && (k % 7 == 0));
`else
            chk("b2b_busy",   busy_b, (k % 9) < 7);
            chk("b2b_sel",    sel_b, ((k % 9) < 7) ? (k % 9) : 6);
            chk("b2b_strobe", strobe_b, (k % 9) < 7);
            chk("b2b_done",   done_b, (k % 9) == 7);
`endif
            chk("b2b_word", word_b, 7'h55);
            step();
        end
        start_b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream driver for the 7-to-1 bit-select mux.
- Captures a 7-bit word on a Start request and presents it unchanged on WordOut, which feeds the mux data input.
- Steps MuxSelect through 0..6, holding each value for CYCLES_PER_BIT clocks, so the mux output becomes a serial bit stream, LSB first.
- Signals completion with a one-cycle Done pulse; it is the timing source for serial-output labs such as LED blinkers and Morse-style senders.

Parameters:
- WIDTH, 7, word width; must equal the mux input count.
- SEL_W, 3, select width; must satisfy 2^SEL_W >= WIDTH.
- CYCLES_PER_BIT, 4, clocks each select value is held; must be >= 1. Set to 25_000_000 for 0.5 s per bit at 50 MHz on the board.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request to begin a scan; sampled only in IDLE.
- DataIn  in  WIDTH  word to serialize; captured on the accepting edge.
- WordOut  out  WIDTH  captured word; connects to the mux data input.
- MuxSelect  out  SEL_W  current bit index; connects to the mux select.
- BitStrobe  out  1  one-cycle pulse on the first cycle of each bit slot.
- Busy  out  1  high while a scan is in progress.
- Done  out  1  one-cycle pulse after the last slot ends.

Behaviour:
- Reset (async, high): state=IDLE, WordOut=0, MuxSelect=0, slot counter=0, BitStrobe=0, Busy=0, Done=0.
- Reset asserted mid-scan aborts the scan immediately; no Done is produced.
- All outputs are registered; there is no combinational path from inputs to outputs.
- States:
  - IDLE: Busy=0. On an edge with Start=1: WordOut<=DataIn, MuxSelect<=0, counter<=CYCLES_PER_BIT-1, BitStrobe<=1, Busy<=1, go to SHIFT.
  - SHIFT: BitStrobe defaults to 0. While counter!=0, decrement it.
  - SHIFT, counter==0 and MuxSelect<WIDTH-1: MuxSelect+=1, counter reloads to CYCLES_PER_BIT-1, BitStrobe<=1.
  - SHIFT, counter==0 and MuxSelect==WIDTH-1: go to DONE with Busy<=0 and Done<=1.
  - DONE: lasts exactly one cycle, then returns to IDLE with Done<=0. WordOut and MuxSelect hold their last values until the next accepted Start.
- Latency: if Start is accepted at edge 0, Busy is high for WIDTH*CYCLES_PER_BIT cycles, and Done is high for the one cycle following edge WIDTH*CYCLES_PER_BIT.
- Boundary rules:
  - Start in SHIFT or DONE is ignored; there is no queueing.
  - Start held high continuously begins a new scan on the first IDLE edge after DONE, i.e. back-to-back scans with a 2-cycle gap.
  - Changes on DataIn during a scan have no effect.
  - MuxSelect never takes values >= WIDTH.
  - With CYCLES_PER_BIT=1, MuxSelect advances every cycle and BitStrobe stays high for the whole scan.

Optional Feature:
- Macro: MUX_SCAN_REPEAT_EN.
- With the macro defined: at the end of the WIDTH-1 slot, if Start=1:
  - Recapture DataIn and set MuxSelect<=0, counter<=CYCLES_PER_BIT-1, BitStrobe<=1.
  - Pulse Done for one cycle, stay in SHIFT and keep Busy=1.
  - The result is gapless continuous scanning.
- With the macro defined and Start=0 at the end of the last slot, behaviour is the same as without the macro.
- Without the macro: the scan always goes through DONE and IDLE as described above.

Decomposition:
- Shared package/header holds:
  - State encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - Defaults for WIDTH and SEL_W, shared with the mux.
  - A counter-width helper (clog2 of CYCLES_PER_BIT).
- Sub-module bit_slot_timer: loadable down-counter with a reload input and a zero-flag output. It is reused as a rate divider elsewhere in the labs.
- The FSM and the select register stay in the top module.

Test Plan:
- Reset check: assert Reset mid-cycle -> all outputs read 0 immediately, before the next clock edge; after release, state is IDLE.
- Single scan: CYCLES_PER_BIT=4, DataIn=7'b1011001, Start pulsed at edge 0 ->
  - MuxSelect = 0,1,…,6, each held 4 cycles.
  - BitStrobe pulses at edges 0,4,…,24.
  - Busy high for 28 cycles; Done high only in the cycle after edge 28.
  - Serial mux output = 1,0,0,1,1,0,1.
- Ignored inputs: Start pulsed at edge 10 and DataIn changed to 7'h7F mid-scan -> WordOut stays 7'b1011001 and Done timing is unchanged.
- Abort: Reset asserted at edge 13 -> Busy=0 and MuxSelect=0 asynchronously; no Done follows; a new Start after Reset release scans normally.
- Back-to-back: Start held high with CYCLES_PER_BIT=1 ->
  - Without MUX_SCAN_REPEAT_EN: scans repeat with Busy low for 2 cycles between them.
  - With MUX_SCAN_REPEAT_EN: MuxSelect wraps 6->0 with no gap, Done pulses every 7 cycles, Busy stays 1.
